// File: rtl/ram_arbiter_sys_if.sv
// rtl/ram_arbiter_sys_if.sv - single-port RAM bus between the arbiter and the ram model
// Ports (modport master = arbiter side, slave = RAM side):
//   ren, wen  read/write strobes, master -> slave
//   addr      access address,    master -> slave
//   store     write data,        master -> slave
//   load      read data,         slave -> master
//   ack       one-cycle access-complete pulse, slave -> master
interface ram_arbiter_sys_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          ren;
  logic          wen;
  logic [AW-1:0] addr;
  logic [DW-1:0] store;
  logic [DW-1:0] load;
  logic          ack;

  modport master (output ren, output wen, output addr, output store, input load, input ack);
  modport slave  (input ren, input wen, input addr, input store, output load, output ack);
endinterface

// File: rtl/ram_arbiter_sys.sv
// rtl/ram_arbiter_sys.sv - CPU clock divider, round-robin RAM arbiter and sticky system halt
// Ports:
//   CLK, RST                     system clock, asynchronous active-high reset
//   cpuclk                       CPU clock, period CLKDIV CLK cycles
//   req_ren/req_wen/req_addr/req_store  NREQ packed requestor channels (channel i at [i*W +: W])
//   req_ack                      one-cycle completion pulse to the granted channel
//   req_load                     RAM read data broadcast to every channel
//   core_halt, sys_halt          per-core halts, sticky all-cores-halted flag
//   tb_ctrl/tb_ren/tb_wen/tb_addr/tb_store  testbench override channel
//   ram                          RAM bus (master modport)
//   wait_cnt                     per-channel 16-bit saturating wait counters, only with ARB_PERF_EN
module ram_arbiter_sys #(
  parameter int NREQ   = 2,
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int CLKDIV = 2
) (
  input  logic               CLK,
  input  logic               RST,
  output logic               cpuclk,
  input  logic [NREQ-1:0]    req_ren,
  input  logic [NREQ-1:0]    req_wen,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_store,
  output logic [NREQ-1:0]    req_ack,
  output logic [DW-1:0]      req_load,
  input  logic [NREQ-1:0]    core_halt,
  output logic               sys_halt,
  input  logic               tb_ctrl,
  input  logic               tb_ren,
  input  logic               tb_wen,
  input  logic [AW-1:0]      tb_addr,
  input  logic [DW-1:0]      tb_store,
  ram_arbiter_sys_if.master  ram
`ifdef ARB_PERF_EN
  , output logic [NREQ*16-1:0] wait_cnt
`endif
);

  localparam int HALF = CLKDIV / 2;
  localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int GW   = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state, nxt_state;
  logic [CW-1:0]   count;
  logic [GW-1:0]   grant, nxt_grant, rr_ptr, nxt_rr, grant_inc;
  logic [NREQ-1:0] requesting;
  logic            found;
  int              idx;

  assign requesting = req_ren | req_wen;
  assign req_load   = ram.load;
  assign grant_inc  = (grant == GW'(NREQ - 1)) ? '0 : grant + 1'b1;

  // Clock divider: half-period of HALF CLK cycles.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count  <= '0;
      cpuclk <= 1'b0;
    end else if (count == CW'(HALF - 1)) begin
      count  <= '0;
      cpuclk <= ~cpuclk;
    end else begin
      count <= count + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= nxt_state;
      grant  <= nxt_grant;
      rr_ptr <= nxt_rr;
    end
  end

  always_comb begin
    nxt_state = state;
    nxt_grant = grant;
    nxt_rr    = rr_ptr;
    found     = 1'b0;
    idx       = 0;
    if (tb_ctrl) begin
      // Override aborts any access in flight; fairness pointer is left alone.
      nxt_state = IDLE;
    end else begin
      case (state)
        IDLE: begin
          for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rr_ptr) + k) % NREQ;
            if (!found && requesting[idx]) begin
              found     = 1'b1;
              nxt_grant = GW'(idx);
            end
          end
          if (found) nxt_state = GRANT;
        end
        GRANT: begin
          // Completion and abandonment both pass the turn to the next channel.
          if (ram.ack || !requesting[grant]) begin
            nxt_state = IDLE;
            nxt_rr    = grant_inc;
          end
        end
        default: nxt_state = IDLE;
      endcase
    end
  end

  always_comb begin
    ram.ren   = 1'b0;
    ram.wen   = 1'b0;
    ram.addr  = '0;
    ram.store = '0;
    req_ack   = '0;
    if (tb_ctrl) begin
      ram.ren   = tb_ren;
      ram.wen   = tb_wen;
      ram.addr  = tb_addr;
      ram.store = tb_store;
    end else if (state == GRANT) begin
      // A write wins when a channel raises both strobes.
      ram.wen   = req_wen[grant];
      ram.ren   = req_ren[grant] & ~req_wen[grant];
      ram.addr  = req_addr[int'(grant)*AW +: AW];
      ram.store = req_store[int'(grant)*DW +: DW];
      if (ram.ack) req_ack[grant] = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) sys_halt <= 1'b0;
    else if (&core_halt) sys_halt <= 1'b1;
  end

`ifdef ARB_PERF_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wait_cnt <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (requesting[i] && !(state == GRANT && int'(grant) == i) &&
            wait_cnt[i*16 +: 16] != 16'hFFFF)
          wait_cnt[i*16 +: 16] <= wait_cnt[i*16 +: 16] + 16'd1;
      end
    end
  end
`endif

endmodule
